// File: rtl/seq_pkg.sv
// Shared definitions for the 110110 framing link: transmitter FSM states and sync word.
// The detector on the receive side uses the same sync constants.
package seq_pkg;

    localparam int SYNC_W = 6;
    localparam logic [SYNC_W-1:0] SYNC_WORD_110110 = 6'b110110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_DATA = 2'd2
    } tx_state_t;

    function automatic int frame_len(input int payload_w);
        return SYNC_W + payload_w;
    endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// Payload load handshake plus serial frame output of seq_frame_tx.
// master = payload source / serial sink, slave = the transmitter.
interface seq_frame_tx_if #(
    parameter int PAYLOAD_W = 8
) ();
    logic                 load_valid;
    logic [PAYLOAD_W-1:0] load_data;
    logic                 load_ready;
    logic                 out;
    logic                 out_valid;
    logic                 frame_start;
    logic                 frame_done;

    modport master (
        output load_valid, load_data,
        input  load_ready, out, out_valid, frame_start, frame_done
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, out, out_valid, frame_start, frame_done
    );
endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-load, left-shift register exposing its MSB; load wins over shift.
// Latency: one clock from load to msb; no backpressure (enables only).
// Backpressure: none, the owner gates load/shift.
module piso_shift_reg #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);
    logic [W-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= q << 1;
        end
    end

    assign msb = q[W-1];
endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: sync word then payload, MSB first, one bit per clock.
// Latency: first sync bit in the cycle after accept; frame lasts SYNC_W+PAYLOAD_W cycles.
// Backpressure: load_ready only in IDLE or on the last payload bit, giving gapless back-to-back frames.
module seq_frame_tx #(
    parameter int                PAYLOAD_W = 8,
    parameter int                SYNC_W    = seq_pkg::SYNC_W,
    parameter logic [SYNC_W-1:0] SYNC_WORD = seq_pkg::SYNC_WORD_110110
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_frame_tx_if.slave bus
);
    import seq_pkg::*;

    localparam int FRAME_W = SYNC_W + PAYLOAD_W;
    localparam int CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(PAYLOAD_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_t        state;
    logic [CNT_W-1:0] cnt;
    logic             active;
    logic             start_int;
    logic             done_int;
    logic             ready_int;
    logic             accept;
    logic             sr_msb;

    // All output decode comes from state/cnt/shift register, never from inputs.
    assign active    = (state != ST_IDLE);
    assign start_int = (state == ST_SYNC) && (cnt == CNT_TOP);
    assign done_int  = (state == ST_DATA) && (cnt == '0);
    assign ready_int = (state == ST_IDLE) || done_int;
    assign accept    = bus.load_valid && ready_int;

    piso_shift_reg #(
        .W (FRAME_W)
    ) u_sr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .shift (active),
        .din   ({SYNC_WORD, bus.load_data}),
        .msb   (sr_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_SYNC;
                        cnt   <= CNT_TOP;
                    end
                end
                ST_SYNC: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_DATA) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Last payload bit: reload directly so the next sync follows with no gap.
                    if (cnt == '0) begin
                        if (accept) begin
                            state <= ST_SYNC;
                            cnt   <= CNT_TOP;
                        end else begin
                            state <= ST_IDLE;
                            cnt   <= '0;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.out         = active & sr_msb;
    assign bus.out_valid   = active;
    assign bus.frame_start = start_int;
    assign bus.frame_done  = done_int;
    assign bus.load_ready  = ready_int;
endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed bench for seq_frame_tx: frame-position model checked every cycle, plus literal frame checks.
module tb_seq_frame_tx;
    localparam int PW = 8;
    localparam int FW = 14;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_frame_tx_if #(.PAYLOAD_W(PW)) bus_if ();

    seq_frame_tx #(.PAYLOAD_W(PW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    int checks = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: position within the current frame (0 = idle, 1..FW = frame cycle).
    int           mpos;
    logic [FW-1:0] mword;
    logic          mrdy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mpos  = 0;
            mword = '0;
        end else begin
            mrdy = (mpos == 0) || (mpos == FW);
            if (bus_if.load_valid && mrdy) begin
                mpos  = 1;
                mword = {6'b110110, bus_if.load_data};
            end else if (mpos != 0 && mpos < FW) begin
                mpos = mpos + 1;
            end else begin
                mpos = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_out",   bus_if.out,         (mpos > 0) ? mword[FW-mpos] : 1'b0);
            check("model_valid", bus_if.out_valid,   mpos > 0);
            check("model_start", bus_if.frame_start, mpos == 1);
            check("model_done",  bus_if.frame_done,  mpos == FW);
            check("model_ready", bus_if.load_ready,  (mpos == 0) || (mpos == FW));
        end
    end

    // Downstream 110110 detector: detect asserts the cycle after the 6th bit is sampled.
    logic [5:0] dhist;
    logic       detect;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dhist  = '0;
            detect = 1'b0;
        end else begin
            dhist  = {dhist[4:0], bus_if.out};
            detect = (dhist == 6'b110110);
        end
    end

    // Call at a negedge while idle; observes cycles 1..16 after the accept edge.
    task automatic run_frame(input logic [7:0] d, input int poke,
                             output logic [FW-1:0] bits, output int vcnt,
                             output int st_c, output int dn_c, output int det_n,
                             output int det_first, output int det_last, output logic tail_out);
        bits = '0; vcnt = 0; st_c = 0; dn_c = 0;
        det_n = 0; det_first = 0; det_last = 0; tail_out = 1'b0;
        bus_if.load_valid = 1'b1;
        bus_if.load_data  = d;
        @(negedge clk);
        bus_if.load_valid = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == poke) begin
                check("poke_ready_low", bus_if.load_ready, 1'b0);
                bus_if.load_valid = 1'b1;
                bus_if.load_data  = 8'h3C;
            end else begin
                bus_if.load_valid = 1'b0;
            end
            if (k <= FW) bits[FW-k] = bus_if.out;
            else         tail_out = tail_out | bus_if.out;
            if (bus_if.out_valid)   vcnt++;
            if (bus_if.frame_start) st_c = k;
            if (bus_if.frame_done)  dn_c = k;
            if (detect) begin
                det_n++;
                if (det_first == 0) det_first = k;
                det_last = k;
            end
            @(negedge clk);
        end
    endtask

    logic [FW-1:0] bits;
    int vcnt, st_c, dn_c, det_n, det_first, det_last;
    logic tail_out;
    logic [27:0] b2b_bits;
    int b2b_v, b2b_first_gap, b2b_done1, b2b_start2, nstart;

    initial begin
        bus_if.load_valid = 1'b0;
        bus_if.load_data  = '0;
        @(negedge clk);
        check("rst_out",   bus_if.out,         1'b0);
        check("rst_valid", bus_if.out_valid,   1'b0);
        check("rst_start", bus_if.frame_start, 1'b0);
        check("rst_done",  bus_if.frame_done,  1'b0);
        check("rst_ready", bus_if.load_ready,  1'b1);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // Single frame A5, also fed to the detector
        run_frame(8'hA5, 0, bits, vcnt, st_c, dn_c, det_n, det_first, det_last, tail_out);
        check("a5_bits",  bits, 14'b11011010100101);
        check("a5_vcnt",  vcnt, 14);
        check("a5_start", st_c, 1);
        check("a5_done",  dn_c, 14);
        check("a5_tail",  tail_out, 1'b0);
        check("a5_det_n", det_n, 1);
        check("a5_det_c", det_first, 7);

        // Back-to-back FF then 00
        b2b_bits = '0; b2b_v = 0; b2b_first_gap = 0; b2b_done1 = 0; b2b_start2 = 0; nstart = 0;
        bus_if.load_valid = 1'b1;
        bus_if.load_data  = 8'hFF;
        @(negedge clk);
        bus_if.load_data = 8'h00;
        for (int k = 1; k <= 30; k++) begin
            if (k == 15) bus_if.load_valid = 1'b0;
            if (k <= 28) b2b_bits[28-k] = bus_if.out;
            if (bus_if.out_valid) b2b_v++;
            else if (b2b_first_gap == 0) b2b_first_gap = k;
            if (bus_if.frame_done && b2b_done1 == 0) b2b_done1 = k;
            if (bus_if.frame_start) begin
                nstart++;
                if (nstart == 2) b2b_start2 = k;
            end
            @(negedge clk);
        end
        check("b2b_bits",   b2b_bits, 28'b1101101111111111011000000000);
        check("b2b_vcnt",   b2b_v, 28);
        check("b2b_gap",    b2b_first_gap, 29);
        check("b2b_done1",  b2b_done1, 14);
        check("b2b_start2", b2b_start2, 15);

        // Load pulse during cycle 5 of an active frame is ignored
        run_frame(8'h5A, 5, bits, vcnt, st_c, dn_c, det_n, det_first, det_last, tail_out);
        check("hs_bits",  bits, 14'b11011001011010);
        check("hs_vcnt",  vcnt, 14);
        check("hs_start", st_c, 1);
        check("hs_tail",  tail_out, 1'b0);
        check("hs_idle",  bus_if.load_ready, 1'b1);

        // Colliding payload: second detection right after payload LSB
        run_frame(8'h36, 0, bits, vcnt, st_c, dn_c, det_n, det_first, det_last, tail_out);
        check("c36_bits",   bits, 14'b11011000110110);
        check("c36_det_n",  det_n, 2);
        check("c36_det_1",  det_first, 7);
        check("c36_det_2",  det_last, 15);

        // Asynchronous reset in cycle 9 of a frame
        bus_if.load_valid = 1'b1;
        bus_if.load_data  = 8'hC3;
        @(negedge clk);
        bus_if.load_valid = 1'b0;
        repeat (7) @(negedge clk);
        @(posedge clk);
        #1;
        check("pre_rst_valid", bus_if.out_valid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out",   bus_if.out,         1'b0);
        check("mid_rst_valid", bus_if.out_valid,   1'b0);
        check("mid_rst_start", bus_if.frame_start, 1'b0);
        check("mid_rst_done",  bus_if.frame_done,  1'b0);
        check("mid_rst_ready", bus_if.load_ready,  1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_valid", bus_if.out_valid, 1'b0);
        run_frame(8'h81, 0, bits, vcnt, st_c, dn_c, det_n, det_first, det_last, tail_out);
        check("r81_bits",  bits, 14'b11011010000001);
        check("r81_vcnt",  vcnt, 14);
        check("r81_start", st_c, 1);
        check("r81_done",  dn_c, 14);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
